selector41_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares one 4:1 data selector among 4 requesters.

---
 rtl/selector41_rr_arbiter.sv | 119 +++++++++++
 tb/tb_selector41_rr_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/selector41_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 selector among four requesters, with valid/ready output.
// Optional burst limit per grant: define ARB_TIMEOUT_EN to release after BURST_MAX transfers.
module selector41_rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int BURST_MAX = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [3:0]       iReq,
  input  logic [WIDTH-1:0] iC0,
  input  logic [WIDTH-1:0] iC1,
  input  logic [WIDTH-1:0] iC2,
  input  logic [WIDTH-1:0] iC3,
  input  logic             iReady,
  output logic [3:0]       oGnt,
  output logic             oS1,
  output logic             oS0,
  output logic [WIDTH-1:0] oZ,
  output logic             oValid
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  if (BURST_MAX < 1 || BURST_MAX > 255) begin : g_bad_burst_max
    $error("BURST_MAX must lie in 1..255");
  end

  logic [0:0] state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] gnt_q, gnt_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] win;
  logic       busy;
  logic       xfer;
  logic       burst_done;

  // First requester at or after ptr, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] pick;
    logic [1:0] cand;
    pick = ptr;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + i[1:0];
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

  assign win  = rr_pick(iReq, ptr_q);
  assign busy = (state_q == ST_BUSY);
  assign xfer = oValid && iReady;

`ifdef ARB_TIMEOUT_EN
  assign burst_done = xfer && (cnt_q == 8'(BURST_MAX - 1));
`else
  assign burst_done = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    if (!busy) begin
      if (|iReq) begin
        state_d = ST_BUSY;
        idx_d   = win;
        gnt_d   = 4'b0001 << win;
        cnt_d   = 8'd0;
      end
    end else begin
      if (xfer && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      // Select lines keep the last channel across the release edge.
      if (!iReq[idx_q] || burst_done) begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        ptr_d   = idx_q + 2'd1;
        cnt_d   = 8'd0;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      ptr_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    oZ = '0;
    if (busy) begin
      case (idx_q)
        2'd0:    oZ = iC0;
        2'd1:    oZ = iC1;
        2'd2:    oZ = iC2;
        default: oZ = iC3;
      endcase
    end
  end

  assign oValid = busy && iReq[idx_q];
  assign oGnt   = gnt_q;
  assign oS1    = idx_q[1];
  assign oS0    = idx_q[0];

endmodule

// File: tb/tb_selector41_rr_arbiter.sv
// Directed bench for selector41_rr_arbiter; expectations are hand-computed status vectors
// {oGnt, oS1, oS0, oValid, oZ}.
module tb_selector41_rr_arbiter;

  logic       iClk = 1'b0;
  logic       iRst;
  logic [3:0] iReq;
  logic [3:0] iC0, iC1, iC2, iC3;
  logic       iReady;
  logic [3:0] oGnt;
  logic       oS1, oS0;
  logic [3:0] oZ;
  logic       oValid;

  logic [10:0] obs;
  logic [10:0] exp_v;
  logic [3:0]  chan [4];
  int n_cmp = 0;
  int n_err = 0;

  selector41_rr_arbiter #(.WIDTH(4), .BURST_MAX(4)) dut (
    .iClk(iClk), .iRst(iRst), .iReq(iReq),
    .iC0(iC0), .iC1(iC1), .iC2(iC2), .iC3(iC3),
    .iReady(iReady), .oGnt(oGnt), .oS1(oS1), .oS0(oS0),
    .oZ(oZ), .oValid(oValid)
  );

  always #5 iClk = ~iClk;

  assign obs = {oGnt, oS1, oS0, oValid, oZ};

  task automatic cyc;
    @(posedge iClk);
    #1;
  endtask

  task automatic test_reset;
    iRst = 1'b1; iReq = 4'b1111; iReady = 1'b1;
    cyc; cyc;
    n_cmp++;
    if (obs !== {4'b0000, 2'b00, 1'b0, 4'b0000}) begin
      n_err++; $display("FAIL reset_hold: got %b required %b", obs, {4'b0000, 2'b00, 1'b0, 4'b0000});
    end
    iRst = 1'b0;
    cyc;
    n_cmp++;
    if (obs !== {4'b0001, 2'b00, 1'b1, 4'b0001}) begin
      n_err++; $display("FAIL reset_first_grant: got %b required %b", obs, {4'b0001, 2'b00, 1'b1, 4'b0001});
    end
    iReq = 4'b1110;
    cyc;
    n_cmp++;
    if (obs !== {4'b0000, 2'b00, 1'b0, 4'b0000}) begin
      n_err++; $display("FAIL reset_release: got %b required %b", obs, {4'b0000, 2'b00, 1'b0, 4'b0000});
    end
    iReq = 4'b0000;
    cyc;
    n_cmp++;
    if (obs !== {4'b0000, 2'b00, 1'b0, 4'b0000}) begin
      n_err++; $display("FAIL idle_no_req: got %b required %b", obs, {4'b0000, 2'b00, 1'b0, 4'b0000});
    end
  endtask

  task automatic test_single;
    iReq = 4'b0100;
    cyc;
    n_cmp++;
    if (obs !== {4'b0100, 2'b10, 1'b1, 4'b0100}) begin
      n_err++; $display("FAIL single_grant: got %b required %b", obs, {4'b0100, 2'b10, 1'b1, 4'b0100});
    end
    iReq = 4'b0000;
    #1;
    n_cmp++;
    if (obs !== {4'b0100, 2'b10, 1'b0, 4'b0100}) begin
      n_err++; $display("FAIL single_drop_valid: got %b required %b", obs, {4'b0100, 2'b10, 1'b0, 4'b0100});
    end
    cyc;
    n_cmp++;
    if (obs !== {4'b0000, 2'b10, 1'b0, 4'b0000}) begin
      n_err++; $display("FAIL single_release: got %b required %b", obs, {4'b0000, 2'b10, 1'b0, 4'b0000});
    end
    // ptr must now be 3: with ch0 and ch3 requesting, ch3 wins.
    iReq = 4'b1001;
    cyc;
    n_cmp++;
    if (obs !== {4'b1000, 2'b11, 1'b1, 4'b1100}) begin
      n_err++; $display("FAIL single_ptr3: got %b required %b", obs, {4'b1000, 2'b11, 1'b1, 4'b1100});
    end
    iReq = 4'b0001;
    cyc;
    n_cmp++;
    if (obs !== {4'b0000, 2'b11, 1'b0, 4'b0000}) begin
      n_err++; $display("FAIL ch3_release: got %b required %b", obs, {4'b0000, 2'b11, 1'b0, 4'b0000});
    end
    iReq = 4'b0000;
    cyc;
  endtask

  task automatic test_round_robin;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] g;
    logic [1:0] s;
    iReq = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      g = 4'b0001 << order[i];
      s = 2'(order[i]);
      cyc;
      exp_v = {g, s, 1'b1, chan[order[i]]};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL rr_grant[%0d]: got %b required %b", i, obs, exp_v);
      end
      iReq = 4'b1111 & ~g;
      cyc;
      exp_v = {4'b0000, s, 1'b0, 4'b0000};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL rr_dead_cycle[%0d]: got %b required %b", i, obs, exp_v);
      end
      iReq = 4'b1111;
    end
    iReq = 4'b0000;
    cyc;
  endtask

  task automatic test_backpressure;
    iReq = 4'b0010; iReady = 1'b0;
    cyc;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (obs !== {4'b0010, 2'b01, 1'b1, 4'b1010}) begin
        n_err++; $display("FAIL bp_stall[%0d]: got %b required %b", i, obs, {4'b0010, 2'b01, 1'b1, 4'b1010});
      end
      cyc;
    end
    iReady = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs !== {4'b0010, 2'b01, 1'b1, 4'b1010}) begin
        n_err++; $display("FAIL bp_flow[%0d]: got %b required %b", i, obs, {4'b0010, 2'b01, 1'b1, 4'b1010});
      end
      if (i < 3) cyc;
    end
`ifndef ARB_TIMEOUT_EN
    iReq = 4'b0000;
`endif
    cyc;
    n_cmp++;
    if (obs !== {4'b0000, 2'b01, 1'b0, 4'b0000}) begin
      n_err++; $display("FAIL bp_release: got %b required %b", obs, {4'b0000, 2'b01, 1'b0, 4'b0000});
    end
    iReq = 4'b0000;
    cyc;
  endtask

  task automatic test_reset_midgrant;
    iReq = 4'b1000; iReady = 1'b1;
    cyc;
    n_cmp++;
    if (obs !== {4'b1000, 2'b11, 1'b1, 4'b1100}) begin
      n_err++; $display("FAIL mid_grant: got %b required %b", obs, {4'b1000, 2'b11, 1'b1, 4'b1100});
    end
    cyc; cyc;
    iRst = 1'b1; iReq = 4'b1010;
    cyc;
    n_cmp++;
    if (obs !== {4'b0000, 2'b00, 1'b0, 4'b0000}) begin
      n_err++; $display("FAIL mid_reset: got %b required %b", obs, {4'b0000, 2'b00, 1'b0, 4'b0000});
    end
    iRst = 1'b0;
    cyc;
    n_cmp++;
    if (obs !== {4'b0010, 2'b01, 1'b1, 4'b1010}) begin
      n_err++; $display("FAIL mid_after_reset: got %b required %b", obs, {4'b0010, 2'b01, 1'b1, 4'b1010});
    end
    iReq = 4'b0000;
    cyc;
  endtask

  task automatic test_burst;
    iRst = 1'b1; iReq = 4'b0000;
    cyc;
    iRst = 1'b0; iReq = 4'b1001; iReady = 1'b1;
    cyc;
    n_cmp++;
    if (obs !== {4'b0001, 2'b00, 1'b1, 4'b0001}) begin
      n_err++; $display("FAIL burst_grant0: got %b required %b", obs, {4'b0001, 2'b00, 1'b1, 4'b0001});
    end
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      cyc;
      n_cmp++;
      if (obs !== {4'b0001, 2'b00, 1'b1, 4'b0001}) begin
        n_err++; $display("FAIL burst_hold[%0d]: got %b required %b", i, obs, {4'b0001, 2'b00, 1'b1, 4'b0001});
      end
    end
`else
    for (int i = 0; i < 6; i++) begin
      cyc;
      n_cmp++;
      if (obs !== {4'b0001, 2'b00, 1'b1, 4'b0001}) begin
        n_err++; $display("FAIL burst_hold[%0d]: got %b required %b", i, obs, {4'b0001, 2'b00, 1'b1, 4'b0001});
      end
    end
    iReq = 4'b1000;
`endif
    cyc;
    n_cmp++;
    if (obs !== {4'b0000, 2'b00, 1'b0, 4'b0000}) begin
      n_err++; $display("FAIL burst_release: got %b required %b", obs, {4'b0000, 2'b00, 1'b0, 4'b0000});
    end
    cyc;
    n_cmp++;
    if (obs !== {4'b1000, 2'b11, 1'b1, 4'b1100}) begin
      n_err++; $display("FAIL burst_next_ch3: got %b required %b", obs, {4'b1000, 2'b11, 1'b1, 4'b1100});
    end
    iReq = 4'b0000;
    cyc; cyc;
  endtask

  initial begin
    iRst = 1'b1; iReq = 4'b0000; iReady = 1'b0;
    iC0 = 4'b0001; iC1 = 4'b1010; iC2 = 4'b0100; iC3 = 4'b1100;
    chan[0] = 4'b0001; chan[1] = 4'b1010; chan[2] = 4'b0100; chan[3] = 4'b1100;
    #1;
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_reset_midgrant;
    test_burst;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
